vector_sequencer: RTL and testbench

Parametrised display-list interpreter for the vector graphics pipeline. Fetches a byte-coded command list from an external list memory and decodes pen, palette and colour commands. Issues line and cubic-curve primitives to a rasteriser over a valid/ready handshake and signals frame completion. Sits between the display-list buffer (SPI-loaded) and the line/curve rasterisers and xy_to_addr stage, replacing fixed-program command decoding.

---
 rtl/vector_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 tb/tb_vector_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// vector_sequencer: display-list interpreter. Fetches byte-coded commands from
// list memory, applies pen/palette/colour commands and hands line and cubic
// primitives to the rasteriser over a valid/ready handshake.
module vector_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 9,
    parameter int unsigned CIDX_W = 4,
    parameter int unsigned PAL_W  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   list_base,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [7:0]          mem_rd_data,
    output logic                pal_wr_en,
    output logic [CIDX_W-1:0]   pal_wr_idx,
    output logic [PAL_W-1:0]    pal_wr_data,
    output logic [CIDX_W-1:0]   color_idx,
    output logic                prim_valid,
    input  logic                prim_ready,
    output logic                prim_cubic,
    output logic [4*X_W-1:0]    prim_x,
    output logic [4*Y_W-1:0]    prim_y,
    input  logic                prim_done,
    output logic                busy,
    output logic                done,
    output logic                frame_show,
    output logic                error,
    output logic [1:0]          error_code
);

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_PAL      = 8'h10;
    localparam logic [7:0] OP_MOVE     = 8'h11;
    localparam logic [7:0] OP_LINE_REL = 8'h12;
    localparam logic [7:0] OP_LINE     = 8'h13;
    localparam logic [7:0] OP_CUBIC    = 8'h15;
    localparam logic [7:0] OP_SET_IDX  = 8'h18;
    localparam logic [7:0] OP_SHOW     = 8'h19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_DECODE,
        S_ARG,
        S_EXEC,
        S_ISSUE,
        S_WAIT_PRIM,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                wrap_q, wrap_d;
    logic [7:0]          op_q, op_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [87:0]         arg_q, arg_d;
    logic                arg_pend_q, arg_pend_d;
    logic [X_W-1:0]      pen_x_q, pen_x_d;
    logic [Y_W-1:0]      pen_y_q, pen_y_d;
    logic [CIDX_W-1:0]   color_idx_q, color_idx_d;
    logic                pal_wr_en_q, pal_wr_en_d;
    logic [CIDX_W-1:0]   pal_wr_idx_q, pal_wr_idx_d;
    logic [PAL_W-1:0]    pal_wr_data_q, pal_wr_data_d;
    logic                prim_valid_q, prim_valid_d;
    logic                prim_cubic_q, prim_cubic_d;
    logic [4*X_W-1:0]    prim_x_q, prim_x_d;
    logic [4*Y_W-1:0]    prim_y_q, prim_y_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                frame_show_q, frame_show_d;
    logic                error_q, error_d;
    logic [1:0]          error_code_q, error_code_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;

    // Combinational helpers
    logic [95:0]         ops;
    logic                issue_rd;
    logic                start_ok;
    logic [3:0]          n_ops;
    logic                bad_op;
    logic signed [7:0]   dx_s;
    logic signed [7:0]   dy_s;
    logic [X_W-1:0]      c1x, c2x, c3x, rel_x;
    logic [Y_W-1:0]      c1y, c2y, c3y, rel_y;

    // Next-state and registered-output computation for the whole interpreter
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wrap_d        = wrap_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        pen_x_d       = pen_x_q;
        pen_y_d       = pen_y_q;
        color_idx_d   = color_idx_q;
        pal_wr_en_d   = 1'b0;
        pal_wr_idx_d  = pal_wr_idx_q;
        pal_wr_data_d = pal_wr_data_q;
        prim_valid_d  = prim_valid_q;
        prim_cubic_d  = prim_cubic_q;
        prim_x_d      = prim_x_q;
        prim_y_d      = prim_y_q;
        busy_d        = busy_q;
        done_d        = done_q;
        frame_show_d  = 1'b0;
        error_d       = error_q;
        error_code_d  = error_code_q;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        arg_pend_d    = 1'b0;
        issue_rd      = 1'b0;
        start_ok      = 1'b0;

        // The last operand byte lands in the EXEC cycle itself, so commands
        // see the operand register with that byte already shifted in.
        ops   = {arg_q, mem_rd_data};
        arg_d = arg_pend_q ? ops[87:0] : arg_q;

        dx_s  = ops[15:8];
        dy_s  = ops[7:0];
        rel_x = pen_x_q + X_W'(dx_s);
        rel_y = pen_y_q + Y_W'(dy_s);
        c1x   = X_W'(ops[95:80]);
        c1y   = Y_W'(ops[79:64]);
        c2x   = X_W'(ops[63:48]);
        c2y   = Y_W'(ops[47:32]);
        c3x   = X_W'(ops[31:16]);
        c3y   = Y_W'(ops[15:0]);

        bad_op = 1'b0;
        case (mem_rd_data)
            OP_NOP:      n_ops = 4'd0;
            OP_PAL:      n_ops = 4'd3;
            OP_MOVE:     n_ops = 4'd4;
            OP_LINE_REL: n_ops = 4'd2;
            OP_LINE:     n_ops = 4'd4;
            OP_CUBIC:    n_ops = 4'd12;
            OP_SET_IDX:  n_ops = 4'd1;
            OP_SHOW:     n_ops = 4'd0;
            default: begin
                n_ops  = 4'd0;
                bad_op = 1'b1;
            end
        endcase

        case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                start_ok = start;
            end
            S_OP: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = mem_rd_data;
                if (bad_op) begin
                    error_d      = 1'b1;
                    error_code_d = 2'b01;
                    state_d      = S_HALT;
                end else if (n_ops == 4'd0) begin
                    state_d = S_EXEC;
                    if (mem_rd_data == OP_SHOW) begin
                        frame_show_d = 1'b1;
                        done_d       = 1'b1;
                    end
                end else begin
                    cnt_d    = n_ops - 4'd1;
                    state_d  = S_ARG;
                    issue_rd = 1'b1;
                end
            end
            S_ARG: begin
                arg_pend_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d    = cnt_q - 4'd1;
                    issue_rd = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_NOP: begin
                        state_d  = S_OP;
                        issue_rd = 1'b1;
                    end
                    OP_PAL: begin
                        pal_wr_en_d   = 1'b1;
                        pal_wr_idx_d  = CIDX_W'(ops[23:16]);
                        pal_wr_data_d = PAL_W'(ops[15:0]);
                        state_d       = S_OP;
                        issue_rd      = 1'b1;
                    end
                    OP_MOVE: begin
                        pen_x_d  = c3x;
                        pen_y_d  = c3y;
                        state_d  = S_OP;
                        issue_rd = 1'b1;
                    end
                    OP_SET_IDX: begin
                        color_idx_d = CIDX_W'(ops[7:0]);
                        state_d     = S_OP;
                        issue_rd    = 1'b1;
                    end
                    OP_LINE, OP_LINE_REL: begin
                        prim_valid_d = 1'b1;
                        prim_cubic_d = 1'b0;
                        if (op_q == OP_LINE) begin
                            prim_x_d = {{(2*X_W){1'b0}}, c3x, pen_x_q};
                            prim_y_d = {{(2*Y_W){1'b0}}, c3y, pen_y_q};
                        end else begin
                            prim_x_d = {{(2*X_W){1'b0}}, rel_x, pen_x_q};
                            prim_y_d = {{(2*Y_W){1'b0}}, rel_y, pen_y_q};
                        end
                        state_d = S_ISSUE;
                    end
                    OP_CUBIC: begin
                        prim_valid_d = 1'b1;
                        prim_cubic_d = 1'b1;
                        prim_x_d     = {c3x, c2x, c1x, pen_x_q};
                        prim_y_d     = {c3y, c2y, c1y, pen_y_q};
                        state_d      = S_ISSUE;
                    end
                    default: begin
                        state_d = S_HALT;
                    end
                endcase
            end
            S_ISSUE: begin
                if (prim_ready) begin
                    prim_valid_d = 1'b0;
                    state_d      = S_WAIT_PRIM;
                end
            end
            S_WAIT_PRIM: begin
                if (prim_done) begin
                    if (prim_cubic_q) begin
                        pen_x_d = prim_x_q[3*X_W +: X_W];
                        pen_y_d = prim_y_q[3*Y_W +: Y_W];
                    end else begin
                        pen_x_d = prim_x_q[X_W +: X_W];
                        pen_y_d = prim_y_q[Y_W +: Y_W];
                    end
                    state_d  = S_OP;
                    issue_rd = 1'b1;
                end
            end
            S_HALT: begin
                busy_d   = 1'b0;
                start_ok = start && !busy_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A read at address 0 after the pc has wrapped is refused and halts.
        if (issue_rd) begin
            if (wrap_q) begin
                error_d      = 1'b1;
                error_code_d = 2'b10;
                state_d      = S_HALT;
            end else begin
                mem_rd_en_d   = 1'b1;
                mem_rd_addr_d = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
                if (pc_q == '1) begin
                    wrap_d = 1'b1;
                end
            end
        end

        if (start_ok) begin
            state_d       = S_OP;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            error_d       = 1'b0;
            error_code_d  = 2'b00;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = list_base;
            pc_d          = list_base + ADDR_W'(1);
            wrap_d        = (list_base == '1);
        end

        // Abort wins over everything and leaves pen, colour, done and error alone.
        if (abort) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            mem_rd_en_d  = 1'b0;
            prim_valid_d = 1'b0;
            pal_wr_en_d  = 1'b0;
            frame_show_d = 1'b0;
            arg_pend_d   = 1'b0;
            pen_x_d      = pen_x_q;
            pen_y_d      = pen_y_q;
            color_idx_d  = color_idx_q;
            done_d       = done_q;
            error_d      = error_q;
            error_code_d = error_code_q;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            wrap_q        <= 1'b0;
            op_q          <= '0;
            cnt_q         <= '0;
            arg_q         <= '0;
            arg_pend_q    <= 1'b0;
            pen_x_q       <= '0;
            pen_y_q       <= '0;
            color_idx_q   <= '0;
            pal_wr_en_q   <= 1'b0;
            pal_wr_idx_q  <= '0;
            pal_wr_data_q <= '0;
            prim_valid_q  <= 1'b0;
            prim_cubic_q  <= 1'b0;
            prim_x_q      <= '0;
            prim_y_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_show_q  <= 1'b0;
            error_q       <= 1'b0;
            error_code_q  <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wrap_q        <= wrap_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            arg_q         <= arg_d;
            arg_pend_q    <= arg_pend_d;
            pen_x_q       <= pen_x_d;
            pen_y_q       <= pen_y_d;
            color_idx_q   <= color_idx_d;
            pal_wr_en_q   <= pal_wr_en_d;
            pal_wr_idx_q  <= pal_wr_idx_d;
            pal_wr_data_q <= pal_wr_data_d;
            prim_valid_q  <= prim_valid_d;
            prim_cubic_q  <= prim_cubic_d;
            prim_x_q      <= prim_x_d;
            prim_y_q      <= prim_y_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_show_q  <= frame_show_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign pal_wr_en   = pal_wr_en_q;
    assign pal_wr_idx  = pal_wr_idx_q;
    assign pal_wr_data = pal_wr_data_q;
    assign color_idx   = color_idx_q;
    assign prim_valid  = prim_valid_q;
    assign prim_cubic  = prim_cubic_q;
    assign prim_x      = prim_x_q;
    assign prim_y      = prim_y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_show  = frame_show_q;
    assign error       = error_q;
    assign error_code  = error_code_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: byte-array list memory, hand-computed
// expectations for palette, drawing, wrap, error and abort behaviour.
module tb_vector_sequencer;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned CIDX_W = 4;
    localparam int unsigned PAL_W  = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   list_base;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [7:0]          mem_rd_data = '0;
    logic                pal_wr_en;
    logic [CIDX_W-1:0]   pal_wr_idx;
    logic [PAL_W-1:0]    pal_wr_data;
    logic [CIDX_W-1:0]   color_idx;
    logic                prim_valid;
    logic                prim_ready;
    logic                prim_cubic;
    logic [4*X_W-1:0]    prim_x;
    logic [4*Y_W-1:0]    prim_y;
    logic                prim_done;
    logic                busy;
    logic                done;
    logic                frame_show;
    logic                error;
    logic [1:0]          error_code;

    logic [7:0] mem [0:4095];
    int checks = 0;
    int errors = 0;
    int pal_cnt = 0;

    vector_sequencer #(
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .CIDX_W (CIDX_W),
        .PAL_W  (PAL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .list_base   (list_base),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .pal_wr_en   (pal_wr_en),
        .pal_wr_idx  (pal_wr_idx),
        .pal_wr_data (pal_wr_data),
        .color_idx   (color_idx),
        .prim_valid  (prim_valid),
        .prim_ready  (prim_ready),
        .prim_cubic  (prim_cubic),
        .prim_x      (prim_x),
        .prim_y      (prim_y),
        .prim_done   (prim_done),
        .busy        (busy),
        .done        (done),
        .frame_show  (frame_show),
        .error       (error),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    // List memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Count palette write pulses
    always @(posedge clk) begin
        if (pal_wr_en) pal_cnt <= pal_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int unsigned base, input int unsigned n, input logic [127:0] v);
        for (int unsigned i = 0; i < n; i++) begin
            mem[(base + i) % 4096] = v[8*(n-1-i) +: 8];
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base);
        repeat (2) @(negedge clk);
        list_base = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (prim_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " prim_valid"}, prim_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_show !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " frame_show"}, frame_show, 1);
        chk({tag, " done"}, done, 1);
    endtask

    task automatic serve_prim(input string tag, input logic cub,
                              input logic [63:0] ex, input logic [63:0] ey);
        wait_valid(tag);
        chk({tag, " cubic"}, prim_cubic, cub);
        chk({tag, " x"}, prim_x, ex);
        chk({tag, " y"}, prim_y, ey);
        prim_ready = 1'b1;
        @(negedge clk);
        prim_ready = 1'b0;
        chk({tag, " valid dropped"}, prim_valid, 0);
        repeat (2) @(negedge clk);
        chk({tag, " waits for done"}, mem_rd_en, 0);
        prim_done = 1'b1;
        @(negedge clk);
        prim_done = 1'b0;
        chk({tag, " fetch after done"}, mem_rd_en, 1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        prim_ready = 1'b0;
        prim_done  = 1'b0;
        list_base  = '0;
        for (int unsigned i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Program 1: PAL(1,0x0C8), SET_IDX 1, SHOW
        load(12'h000, 4, 32'h10_01_00C8);
        load(12'h004, 2, 16'h18_01);
        load(12'h006, 1, 8'h19);
        // Program 2: MOVE(40,80), LINE(200,120), LINE_REL(+1,-1), SHOW
        load(12'h100, 5, 40'h11_0028_0050);
        load(12'h105, 5, 40'h13_00C8_0078);
        load(12'h10A, 3, 24'h12_01_FF);
        load(12'h10D, 1, 8'h19);
        // Program 3: MOVE(5,3), LINE_REL(-10,+2), MOVE(0,0), CUBIC, LINE_REL(0,0), SHOW
        load(12'h200, 5, 40'h11_0005_0003);
        load(12'h205, 3, 24'h12_F6_02);
        load(12'h208, 5, 40'h11_0000_0000);
        load(12'h20D, 13, 104'h15_000A_000A_0014_001E_027F_018F);
        load(12'h21A, 3, 24'h12_00_00);
        load(12'h21D, 1, 8'h19);
        // Bad opcode
        load(12'h300, 1, 8'h14);
        // LINE to (1,1), SHOW
        load(12'h400, 5, 40'h13_0001_0001);
        load(12'h405, 1, 8'h19);
        // SET_IDX 3 in the last two bytes before the wrap
        load(12'hFFE, 2, 16'h18_03);

        repeat (3) @(negedge clk);
        chk("reset status", {busy, done, error, error_code, frame_show}, 0);
        chk("reset handshake", {prim_valid, mem_rd_en, pal_wr_en}, 0);
        chk("reset color_idx", color_idx, 0);
        chk("reset prim_x", prim_x, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle mem_rd_en", mem_rd_en, 0);

        // Program 1 with exact cycle positions
        pulse_start(12'h000);
        chk("p1 first read en", mem_rd_en, 1);
        chk("p1 first read addr", mem_rd_addr, 12'h000);
        chk("p1 busy", busy, 1);
        repeat (5) @(negedge clk);
        chk("p1 pal not yet", pal_wr_en, 0);
        @(negedge clk);
        chk("p1 pal_wr_en", pal_wr_en, 1);
        chk("p1 pal_wr_idx", pal_wr_idx, 1);
        chk("p1 pal_wr_data", pal_wr_data, 10'h0C8);
        repeat (6) @(negedge clk);
        chk("p1 frame_show", frame_show, 1);
        chk("p1 done", done, 1);
        chk("p1 color_idx", color_idx, 1);
        @(negedge clk);
        chk("p1 frame_show pulse", frame_show, 0);
        chk("p1 busy in halt entry", busy, 1);
        @(negedge clk);
        chk("p1 busy dropped", busy, 0);
        chk("p1 pal pulse count", pal_cnt, 1);

        // Program 2: line held by backpressure, stray prim_done ignored
        pulse_start(12'h100);
        chk("p2 done cleared", done, 0);
        wait_valid("p2 line");
        for (int i = 0; i < 5; i++) begin
            prim_done = (i == 2);
            @(negedge clk);
            chk("p2 hold valid", prim_valid, 1);
            chk("p2 hold x", prim_x, {10'd0, 10'd0, 10'd200, 10'd40});
            chk("p2 hold y", prim_y, {9'd0, 9'd0, 9'd120, 9'd80});
        end
        prim_done = 1'b0;
        serve_prim("p2 line", 1'b0, {10'd0, 10'd0, 10'd200, 10'd40},
                   {9'd0, 9'd0, 9'd120, 9'd80});
        chk("p2 next opcode addr", mem_rd_addr, 12'h10A);
        serve_prim("p2 rel", 1'b0, {10'd0, 10'd0, 10'd201, 10'd200},
                   {9'd0, 9'd0, 9'd119, 9'd120});
        wait_done("p2");

        // Program 3: modulo wrap on LINE_REL, cubic slots, pen after cubic
        pulse_start(12'h200);
        serve_prim("p3 rel wrap", 1'b0, {10'd0, 10'd0, 10'd1019, 10'd5},
                   {9'd0, 9'd0, 9'd5, 9'd3});
        serve_prim("p3 cubic", 1'b1, {10'd639, 10'd20, 10'd10, 10'd0},
                   {9'd399, 9'd30, 9'd10, 9'd0});
        serve_prim("p3 pen after cubic", 1'b0, {10'd0, 10'd0, 10'd639, 10'd639},
                   {9'd0, 9'd0, 9'd399, 9'd399});
        wait_done("p3");

        // Bad opcode
        pulse_start(12'h300);
        chk("bad done cleared", done, 0);
        repeat (2) @(negedge clk);
        chk("bad error", error, 1);
        chk("bad error_code", error_code, 2'b01);
        chk("bad no prim", prim_valid, 0);
        @(negedge clk);
        chk("bad busy dropped", busy, 0);

        // pc wrap: SET_IDX at 0xFFE executes, nothing from address 0 does
        pulse_start(12'hFFE);
        chk("wrap error cleared", {error, error_code}, 0);
        repeat (4) @(negedge clk);
        chk("wrap error", error, 1);
        chk("wrap error_code", error_code, 2'b10);
        chk("wrap color_idx", color_idx, 3);
        chk("wrap no read", mem_rd_en, 0);
        @(negedge clk);
        chk("wrap busy dropped", busy, 0);
        chk("wrap no palette write", pal_cnt, 1);

        // Abort during ISSUE, after an ignored start while busy
        pulse_start(12'h400);
        wait_valid("ab line");
        chk("ab x", prim_x, {10'd0, 10'd0, 10'd1, 10'd639});
        list_base = 12'h000;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        chk("ab start while busy", prim_valid, 1);
        chk("ab start while busy rd", mem_rd_en, 0);
        abort      = 1'b1;
        prim_ready = 1'b1;
        @(negedge clk);
        abort      = 1'b0;
        prim_ready = 1'b0;
        chk("ab valid dropped", prim_valid, 0);
        chk("ab busy dropped", busy, 0);
        chk("ab no read", mem_rd_en, 0);
        @(negedge clk);
        chk("ab stays idle", {prim_valid, mem_rd_en, busy}, 0);
        pulse_start(12'h400);
        chk("ab rerun addr", mem_rd_addr, 12'h400);
        chk("ab rerun en", mem_rd_en, 1);
        serve_prim("ab rerun", 1'b0, {10'd0, 10'd0, 10'd1, 10'd639},
                   {9'd0, 9'd0, 9'd1, 9'd399});
        wait_done("ab rerun");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab keeps done", done, 1);
        chk("ab keeps color", color_idx, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
